// File: rtl/char_term_writer.sv
// Text-terminal writer: ASCII byte stream in, glyph writes to a 70x30 char buffer.
// Handles cursor motion, wrap, backspace, full-screen scroll and clear.
module char_term_writer #(
    parameter int H_CHARS = 70,
    parameter int V_CHARS = 30,
    parameter int ADDR_W  = 15
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [6:0]        cur_h,
    output logic [4:0]        cur_v,
    output logic              busy
);

    localparam logic [6:0] H_MAX  = 7'(H_CHARS - 1);
    localparam logic [4:0] V_MAX  = 5'(V_CHARS - 1);
    localparam logic [4:0] V_LAST = 5'(V_CHARS - 2);
    localparam logic [ADDR_W-13:0] PAD = '0;

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_PUT, S_SCR_RD, S_SCR_WR, S_SCR_BLANK
    } state_t;

    state_t     r_state, w_next;
    logic [6:0] r_h, r_sh, r_wh, w_nh, w_ph;
    logic [4:0] r_v, r_sv, r_wv, w_nv, w_pv;
    logic [7:0] r_wd, w_pd;
    logic       r_we, r_scr;
    logic       w_acc, w_put, w_scr, w_clr;
    logic       w_print, w_nl, w_bs, w_ff;

    assign w_acc   = in_valid && (r_state == S_IDLE);
    assign w_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign w_nl    = (in_data == 8'h0A) || (in_data == 8'h0D);
    assign w_bs    = (in_data == 8'h08);
    assign w_ff    = (in_data == 8'h0C);

    // Decode of the accepted byte: next cursor and optional write target
    always_comb begin
        w_nh  = r_h;
        w_nv  = r_v;
        w_ph  = r_h;
        w_pv  = r_v;
        w_pd  = in_data;
        w_put = 1'b0;
        w_scr = 1'b0;
        w_clr = 1'b0;
        if (w_acc) begin
            unique case (1'b1)
                w_print: begin
                    w_put = 1'b1;
                    if (r_h == H_MAX) begin
                        w_nh = 7'd0;
                        if (r_v == V_MAX) w_scr = 1'b1;
                        else              w_nv  = r_v + 5'd1;
                    end else begin
                        w_nh = r_h + 7'd1;
                    end
                end
                w_nl: begin
                    w_nh = 7'd0;
                    if (r_v == V_MAX) w_scr = 1'b1;
                    else              w_nv  = r_v + 5'd1;
                end
                w_bs: begin
                    w_pd = 8'h20;
                    if (r_h != 7'd0) begin
                        w_put = 1'b1;
                        w_nh  = r_h - 7'd1;
                        w_ph  = r_h - 7'd1;
                    end else if (r_v != 5'd0) begin
                        w_put = 1'b1;
                        w_nh  = H_MAX;
                        w_nv  = r_v - 5'd1;
                        w_ph  = H_MAX;
                        w_pv  = r_v - 5'd1;
                    end
                end
                w_ff: begin
                    w_clr = 1'b1;
                    w_nh  = 7'd0;
                    w_nv  = 5'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) r_state <= S_CLEAR;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR:
                if (r_sh == H_MAX && r_sv == V_MAX) w_next = S_IDLE;
            S_IDLE:
                if (w_clr)      w_next = S_CLEAR;
                else if (w_put) w_next = S_PUT;
                else if (w_scr) w_next = S_SCR_RD;
            S_PUT:
                w_next = r_scr ? S_SCR_RD : S_IDLE;
            S_SCR_RD:
                w_next = S_SCR_WR;
            S_SCR_WR:
                if (r_sh == H_MAX && r_sv == V_LAST) w_next = S_SCR_BLANK;
                else                                 w_next = S_SCR_RD;
            S_SCR_BLANK:
                if (r_sh == H_MAX) w_next = S_IDLE;
            default:
                w_next = S_CLEAR;
        endcase
    end

    always_comb begin
        in_ready = (r_state == S_IDLE);
        busy     = (r_state == S_CLEAR) || (r_state == S_SCR_RD) ||
                   (r_state == S_SCR_WR) || (r_state == S_SCR_BLANK);
        rd_addr  = '0;
        if (r_state == S_SCR_RD) rd_addr = {PAD, r_sh, r_sv + 5'd1};
    end

    // Scan counters (r_sh/r_sv) return to zero at the end of every sweep
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_h   <= 7'd0;
            r_v   <= 5'd0;
            r_sh  <= 7'd0;
            r_sv  <= 5'd0;
            r_scr <= 1'b0;
            r_we  <= 1'b0;
            r_wh  <= 7'd0;
            r_wv  <= 5'd0;
            r_wd  <= 8'd0;
        end else begin
            r_we <= 1'b0;
            r_h  <= w_nh;
            r_v  <= w_nv;
            if (w_acc) r_scr <= w_scr;
            case (r_state)
                S_IDLE: if (w_put) begin
                    r_we <= 1'b1;
                    r_wh <= w_ph;
                    r_wv <= w_pv;
                    r_wd <= w_pd;
                end
                S_CLEAR: begin
                    r_we <= 1'b1;
                    r_wh <= r_sh;
                    r_wv <= r_sv;
                    r_wd <= 8'h20;
                    if (r_sh == H_MAX) begin
                        r_sh <= 7'd0;
                        r_sv <= (r_sv == V_MAX) ? 5'd0 : r_sv + 5'd1;
                    end else begin
                        r_sh <= r_sh + 7'd1;
                    end
                end
                S_SCR_WR: begin
                    r_we <= 1'b1;
                    r_wh <= r_sh;
                    r_wv <= r_sv;
                    r_wd <= rd_data;
                    if (r_sh == H_MAX) begin
                        r_sh <= 7'd0;
                        r_sv <= (r_sv == V_LAST) ? 5'd0 : r_sv + 5'd1;
                    end else begin
                        r_sh <= r_sh + 7'd1;
                    end
                end
                S_SCR_BLANK: begin
                    r_we <= 1'b1;
                    r_wh <= r_sh;
                    r_wv <= V_MAX;
                    r_wd <= 8'h20;
                    r_sh <= (r_sh == H_MAX) ? 7'd0 : r_sh + 7'd1;
                end
                default: ;
            endcase
        end
    end

    assign wr_en   = r_we;
    assign wr_addr = {PAD, r_wh, r_wv};
    assign wr_data = r_wd;
    assign cur_h   = r_h;
    assign cur_v   = r_v;

endmodule

// File: tb/tb_char_term_writer.sv
// Bench for char_term_writer: table of single-byte vectors plus
// clear, scroll, held-input and mid-scroll reset sequences.
module tb_char_term_writer;

    logic        clk_50m = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic [14:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic [6:0]  cur_h;
    logic [4:0]  cur_v;
    logic        busy;

    always #10 clk_50m = ~clk_50m;

    char_term_writer dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .cur_h   (cur_h),
        .cur_v   (cur_v),
        .busy    (busy)
    );

    function automatic logic [14:0] A(input int h, input int v);
        return {3'b000, 7'(h), 5'(v)};
    endfunction

    function automatic logic [7:0] pat(input int h, input int v);
        return 8'(v * 37 + h + 1);
    endfunction

    // Character buffer model: 1-cycle read latency, write on strobe
    logic [7:0] mem [0:32767];
    int wc  [0:32767];
    int wc0 [0:32767];
    int nwr = 0, n41 = 0, preq = 0, pseen = 0;

    always @(posedge clk_50m) begin
        rd_data <= mem[rd_addr];
        if (preq != pseen) begin
            pseen = preq;
            for (int v = 0; v < 30; v++)
                for (int h = 0; h < 70; h++)
                    mem[A(h, v)] = pat(h, v);
        end
        if (wr_en) begin
            mem[wr_addr] = wr_data;
            wc[wr_addr]  = wc[wr_addr] + 1;
            nwr = nwr + 1;
            if (wr_addr == A(0, 29) && wr_data == 8'h41) n41 = n41 + 1;
        end
    end

    int tests = 0, fails = 0, nw0 = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 10000) begin
            @(negedge clk_50m);
            n++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk_50m);
        wait_ready(n);
        if (!in_ready) chk("ready_timeout", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk_50m);
        #1 in_valid = 1'b0;
        @(negedge clk_50m);
    endtask

    task automatic snap();
        for (int i = 0; i < 32768; i++) wc0[i] = wc[i];
        nw0 = nwr;
    endtask

    task automatic chk_clear(input string nm);
        int good = 0;
        for (int v = 0; v < 30; v++)
            for (int h = 0; h < 70; h++)
                if (wc[A(h, v)] - wc0[A(h, v)] == 1 && mem[A(h, v)] == 8'h20)
                    good++;
        chk({nm, "_cells"}, good, 2100);
        chk({nm, "_writes"}, nwr - nw0, 2100);
    endtask

    task automatic chk_cur(input string nm, input int h, input int v);
        chk({nm, "_h"}, int'(cur_h), h);
        chk({nm, "_v"}, int'(cur_v), v);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       we;
        int         ah;
        int         av;
        logic [7:0] d;
        int         h;
        int         v;
    } vec_t;

    vec_t tv [13];

    initial begin
        int n, bad, c41;
        tv[0]  = '{8'h41, 1'b1, 0,  0, 8'h41, 1,  0};
        tv[1]  = '{8'h42, 1'b1, 1,  0, 8'h42, 2,  0};
        tv[2]  = '{8'h08, 1'b1, 1,  0, 8'h20, 1,  0};
        tv[3]  = '{8'h07, 1'b0, 0,  0, 8'h00, 1,  0};
        tv[4]  = '{8'h0D, 1'b0, 0,  0, 8'h00, 0,  1};
        tv[5]  = '{8'h08, 1'b1, 69, 0, 8'h20, 69, 0};
        tv[6]  = '{8'h43, 1'b1, 69, 0, 8'h43, 0,  1};
        tv[7]  = '{8'h0A, 1'b0, 0,  0, 8'h00, 0,  2};
        tv[8]  = '{8'h7E, 1'b1, 0,  2, 8'h7E, 1,  2};
        tv[9]  = '{8'h1F, 1'b0, 0,  0, 8'h00, 1,  2};
        tv[10] = '{8'h7F, 1'b0, 0,  0, 8'h00, 1,  2};
        tv[11] = '{8'h20, 1'b1, 1,  2, 8'h20, 2,  2};
        tv[12] = '{8'h80, 1'b0, 0,  0, 8'h00, 2,  2};

        repeat (3) @(posedge clk_50m);
        @(negedge clk_50m);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk_cur("rst_cur", 0, 0);

        snap();
        rst = 1'b0;
        wait_ready(n);
        chk("clear_cycles", n, 2100);
        @(negedge clk_50m);
        chk_clear("clear0");
        chk_cur("clear0_cur", 0, 0);

        for (int i = 0; i < 13; i++) begin
            send(tv[i].b);
            chk($sformatf("vec%0d_we", i), int'(wr_en), int'(tv[i].we));
            if (tv[i].we) begin
                chk($sformatf("vec%0d_addr", i), int'(wr_addr), int'(A(tv[i].ah, tv[i].av)));
                chk($sformatf("vec%0d_data", i), int'(wr_data), int'(tv[i].d));
            end
            chk_cur($sformatf("vec%0d_cur", i), tv[i].h, tv[i].v);
            @(negedge clk_50m);
            chk($sformatf("vec%0d_strobe", i), int'(wr_en), 0);
        end

        send(8'h0C);
        chk_cur("ff_cur", 0, 0);
        chk("ff_busy", int'(busy), 1);
        snap();
        wait_ready(n);
        @(negedge clk_50m);
        chk_clear("clear_ff");

        repeat (5) send(8'h0A);
        repeat (69) send(8'h78);
        chk_cur("at_69_5", 69, 5);
        send(8'h5A);
        chk("wrapZ_addr", int'(wr_addr), int'(A(69, 5)));
        chk("wrapZ_data", int'(wr_data), 8'h5A);
        chk_cur("wrapZ_cur", 0, 6);
        send(8'h08);
        chk("bsrow_we", int'(wr_en), 1);
        chk("bsrow_addr", int'(wr_addr), int'(A(69, 5)));
        chk("bsrow_data", int'(wr_data), 8'h20);
        chk_cur("bsrow_cur", 69, 5);

        send(8'h0C);
        wait_ready(n);
        send(8'h08);
        chk("bs00_we", int'(wr_en), 0);
        chk_cur("bs00_cur", 0, 0);

        repeat (29) send(8'h0A);
        repeat (3) send(8'h78);
        chk_cur("at_3_29", 3, 29);
        @(negedge clk_50m);
        preq = preq + 1;
        snap();
        send(8'h0A);
        chk_cur("scroll_cur0", 0, 29);
        chk("scroll_ready0", int'(in_ready), 0);
        n = 0;
        while (busy && n < 6000) begin
            n++;
            @(negedge clk_50m);
        end
        chk("scroll_cycles", n, 4130);
        chk("scroll_ready1", int'(in_ready), 1);
        @(negedge clk_50m);
        bad = 0;
        for (int v = 0; v < 29; v++)
            for (int h = 0; h < 70; h++)
                if (mem[A(h, v)] != pat(h, v + 1)) bad++;
        for (int h = 0; h < 70; h++)
            if (mem[A(h, 29)] != 8'h20) bad++;
        chk("scroll_rows", bad, 0);
        chk("scroll_writes", nwr - nw0, 2100);
        chk_cur("scroll_cur", 0, 29);

        send(8'h0A);
        c41 = n41;
        in_valid = 1'b1;
        in_data  = 8'h41;
        wait_ready(n);
        chk("hold_not_early", n41 - c41, 0);
        chk_cur("hold_cur_wait", 0, 29);
        @(posedge clk_50m);
        #1 in_valid = 1'b0;
        @(negedge clk_50m);
        chk("hold_we", int'(wr_en), 1);
        chk_cur("hold_cur", 1, 29);
        repeat (3) @(negedge clk_50m);
        chk("hold_once", n41 - c41, 1);
        chk("hold_mem", int'(mem[A(0, 29)]), 8'h41);

        send(8'h0A);
        repeat (100) @(negedge clk_50m);
        chk("mid_busy", int'(busy), 1);
        #5 rst = 1'b1;
        #1;
        chk("mrst_wr_en", int'(wr_en), 0);
        chk("mrst_busy", int'(busy), 1);
        chk("mrst_ready", int'(in_ready), 0);
        chk("mrst_rd_addr", int'(rd_addr), 0);
        chk_cur("mrst_cur", 0, 0);
        snap();
        repeat (2) @(negedge clk_50m);
        rst = 1'b0;
        wait_ready(n);
        chk("mrst_clear_cycles", n, 2100);
        @(negedge clk_50m);
        chk_clear("clear_mrst");
        chk_cur("mrst_cur_end", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/char_term_writer.md
Name: char_term_writer

Overview:
- Text-terminal front end that sits directly upstream of the VGA text display.
- Accepts a stream of ASCII bytes (keyboard/CPU) over a valid/ready handshake and maintains a cursor on the 70x30 character grid.
- Writes glyph codes into the character buffer that the display reads at address {3'b000, h_char, v_char}.
- Handles newline, backspace, line wrap, full-screen scroll and clear-screen; exports the cursor position for display.

Parameters:
- H_CHARS, 70, characters per line (h index 0..69)
- V_CHARS, 30, lines per screen (v index 0..29)
- ADDR_W, 15, character buffer address width

Ports:
- clk_50m  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ASCII byte present
- in_data  in  8  ASCII byte
- in_ready  out  1  block accepts byte this cycle
- wr_en  out  1  char buffer write strobe
- wr_addr  out  ADDR_W  write address {3'b000, h[6:0], v[4:0]}
- wr_data  out  8  byte written
- rd_addr  out  ADDR_W  char buffer read address, same format
- rd_data  in  8  read data; valid exactly 1 cycle after rd_addr is presented
- cur_h  out  7  cursor column
- cur_v  out  5  cursor row
- busy  out  1  scroll or clear in progress

Behaviour:
- Reset (asynchronous):
  - cur_h=0, cur_v=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, in_ready=0, busy=1.
  - State is CLEAR. Reset asserted mid-operation aborts it immediately and restarts CLEAR after release.
- States: CLEAR, IDLE, PUT, SCR_RD, SCR_WR, SCR_BLANK.
- IDLE:
  - in_ready=1, busy=0.
  - A byte is accepted when in_valid && in_ready. It is decoded in the same cycle and produces outputs next cycle.
- Printable byte 0x20..0x7E:
  - Next cycle: wr_en=1, wr_addr={cur_h,cur_v}, wr_data=byte. The FSM passes through PUT for 1 cycle with in_ready=0.
  - Cursor advance: h+1. If h==69, then h=0, v+1.
  - If v would exceed 29: v stays 29, h=0, enter SCR_RD.
- 0x0A or 0x0D:
  - No write; h=0, v+1.
  - If v==29: enter scroll, cursor becomes (0,29).
- 0x08 backspace:
  - h>0: cursor (h-1,v), write 0x20 there.
  - h==0 and v>0: cursor (69,v-1), write 0x20 there.
  - (0,0): no-op, byte consumed.
- 0x0C: cursor (0,0), enter CLEAR.
- All other bytes: consumed, ignored, no write.
- Scroll copy, for v=0..28 and h=0..69, row-major (h inner):
  - SCR_RD drives rd_addr={h,v+1}.
  - SCR_WR writes rd_data to {h,v}.
  - 2 cycles per char.
- SCR_BLANK: writes 0x20 to every h of row 29 at 1 per cycle.
- Scroll totals 2030*2+70 = 4130 cycles, then returns to IDLE.
- CLEAR:
  - Writes 0x20 to all 2100 cells, v outer 0..29, h inner 0..69, 1 per cycle, 2100 cycles.
  - Then IDLE with cursor (0,0).
- in_ready=0 and busy=1 throughout CLEAR/SCR_*. in_ready=0 in PUT.
- wr_en is a single-cycle strobe per write and 0 in all other cycles.
- Address bits [14:12] are always 0.
- Addresses never exceed h=69 or v=29. Column/row counters wrap exactly at H_CHARS-1/V_CHARS-1.
- cur_h/cur_v update on the cycle the byte is consumed, as registered outputs.
- in_data is sampled only when in_valid && in_ready. A held in_valid during busy is not consumed.

Test Plan:
- Release reset -> exactly 2100 writes of 0x20 covering each address once, then in_ready=1, cur=(0,0).
- Send 'A'(0x41), 'B' -> writes 0x41@{0,0}, 0x42@{1,0}; cur=(2,0).
- Cursor at (69,5), send 'Z' -> write 0x5A@{69,5}, cur=(0,6). Then send 0x08 -> write 0x20@{69,5}, cur=(69,5). At (0,0), 0x08 -> no write, cur=(0,0).
- Preload rows with distinct values, cursor (3,29), send 0x0A -> busy for 4130 cycles. Row k holds old row k+1 for k=0..28, row 29 is all 0x20, cur=(0,29), in_ready rises after.
- Hold in_valid with 0x41 during a scroll -> not consumed until in_ready=1, then written exactly once.
- Assert rst mid-scroll -> outputs reset immediately, full clear follows, cur=(0,0).
